// File: rtl/item_spawner.sv
// Food-item coordinate generator: LFSR draws, wall rejection, then body-occupancy scan.
// Define ITEM_SPAWN_FAST_CHECK_EN for a single-cycle parallel body compare; default is a serial scan.
module item_spawner #(
    parameter int          XSIZE    = 48,
    parameter int          YSIZE    = 64,
    parameter int          MAX_SIZE = 100,
    parameter logic [11:0] SEED     = 12'hACE
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Req,
    input  logic [MAX_SIZE*6-1:0] i_Body_x,
    input  logic [MAX_SIZE*6-1:0] i_Body_y,
    input  logic [11:0]           i_Size,
    output logic [5:0]            o_Item_x,
    output logic [5:0]            o_Item_y,
    output logic                  o_Done,
    output logic                  o_Busy
);
    // LATCH is a one-cycle commit step between the accept decision and DONE.
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DRAW  = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] LATCH = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [5:0]  X_LAST   = 6'(XSIZE - 1);
    localparam logic [5:0]  Y_LAST   = 6'(YSIZE - 1);
    localparam logic [5:0]  X_RST    = 6'(XSIZE >> 2);
    localparam logic [5:0]  Y_RST    = 6'(YSIZE >> 2);
    localparam logic [11:0] MAX_S12  = 12'(MAX_SIZE);
    localparam logic [6:0]  MAX_S7   = 7'(MAX_SIZE);

    logic [2:0]  state;
    logic [11:0] lfsr;
    logic [11:0] lfsr_next;
    logic [5:0]  draw_x, draw_y;
    logic [5:0]  cand_x, cand_y;
    logic [6:0]  eff_size, size_q;
    logic        wall;
    logic        hit;
    logic        last;

    assign lfsr_next = {lfsr[10:0], lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3]};
    assign draw_x    = lfsr[5:0];
    assign draw_y    = lfsr[11:6];
    assign wall      = (draw_x == 6'd0) || (draw_x >= X_LAST) ||
                       (draw_y == 6'd0) || (draw_y >= Y_LAST);
    assign eff_size  = (i_Size > MAX_S12) ? MAX_S7 : i_Size[6:0];

    assign o_Done = (state == DONE);
    assign o_Busy = (state == DRAW) || (state == CHECK);

`ifdef ITEM_SPAWN_FAST_CHECK_EN
    logic [MAX_SIZE-1:0] slot_hit;

    for (genvar k = 0; k < MAX_SIZE; k++) begin : g_slot
        assign slot_hit[k] = (7'(k) < size_q) &&
                             (i_Body_x[k*6 +: 6] == cand_x) &&
                             (i_Body_y[k*6 +: 6] == cand_y);
    end

    assign hit  = |slot_hit;
    assign last = 1'b1;
`else
    logic [6:0] idx;

    assign hit  = (i_Body_x[6*idx +: 6] == cand_x) && (i_Body_y[6*idx +: 6] == cand_y);
    assign last = (idx == size_q - 7'd1);

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            idx <= '0;
        end else if (state == DRAW) begin
            idx <= '0;
        end else if (state == CHECK && !hit && !last) begin
            idx <= idx + 7'd1;
        end
    end
`endif

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state    <= IDLE;
            lfsr     <= SEED;
            cand_x   <= '0;
            cand_y   <= '0;
            size_q   <= '0;
            o_Item_x <= X_RST;
            o_Item_y <= Y_RST;
        end else begin
            lfsr <= lfsr_next;
            case (state)
                IDLE: if (i_Req) state <= DRAW;
                DRAW: begin
                    cand_x <= draw_x;
                    cand_y <= draw_y;
                    size_q <= eff_size;
                    if (!wall) state <= (eff_size == 7'd0) ? LATCH : CHECK;
                end
                CHECK: begin
                    if (hit)       state <= DRAW;
                    else if (last) state <= LATCH;
                end
                LATCH: begin
                    o_Item_x <= cand_x;
                    o_Item_y <= cand_y;
                    state    <= DONE;
                end
                DONE:    if (!i_Req) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_item_spawner.sv
// Scoreboard bench for item_spawner: issue side pushes modelled coordinate and done cycle,
// a negedge monitor pops and compares on every rising o_Done.
module tb_item_spawner;
    typedef struct {
        logic [5:0] x;
        logic [5:0] y;
        int         at;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req = 1'b0;
    logic [599:0] bx  = '0;
    logic [599:0] by  = '0;
    logic [11:0]  size = '0;
    logic [5:0]   item_x, item_y;
    logic         done, busy;

    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;
    exp_t  q[$];
    logic [11:0] mlfsr;
    logic  done_d = 1'b0;
    logic [5:0] ex, ey;

    always #5 clk = ~clk;

    item_spawner dut (
        .i_Clk(clk), .i_Rst(rst), .i_Req(req),
        .i_Body_x(bx), .i_Body_y(by), .i_Size(size),
        .o_Item_x(item_x), .o_Item_y(item_y), .o_Done(done), .o_Busy(busy)
    );

    function automatic logic [11:0] nxt(input logic [11:0] l);
        return {l[10:0], l[11] ^ l[10] ^ l[9] ^ l[3]};
    endfunction

    function automatic bit is_wall(input logic [11:0] l);
        return (l[5:0] == 0) || (l[5:0] >= 47) || (l[11:6] == 0) || (l[11:6] >= 63);
    endfunction

    // Cycle-level reference: DRAW costs one cycle, each scanned slot one more, accept adds the commit cycle.
    function automatic void model(input logic [11:0] l0, input int sz,
                                  output logic [5:0] x, output logic [5:0] y, output int lat);
        logic [11:0] l;
        int n, t;
        bit ok;
        logic [5:0] cx, cy;
        l = l0; t = 0; ok = 0; x = 0; y = 0;
        n = (sz > 100) ? 100 : sz;
        while (!ok && t < 20000) begin
            cx = l[5:0]; cy = l[11:6];
            t++; l = nxt(l);
            if (cx == 0 || cx >= 47 || cy == 0 || cy >= 63) continue;
            ok = 1;
            for (int k = 0; k < n; k++) begin
                t++; l = nxt(l);
                if (bx[k*6 +: 6] == cx && by[k*6 +: 6] == cy) begin
                    ok = 0;
                    break;
                end
            end
            if (ok) begin x = cx; y = cy; end
        end
        lat = t + 1;
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) mlfsr <= 12'hACE;
        else      mlfsr <= nxt(mlfsr);
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            done_d = 1'b0;
        end else begin
            if (done && !done_d) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("item_x", int'(item_x), int'(e.x));
                    chk("item_y", int'(item_y), int'(e.y));
                    chk("done_cycle", cyc, e.at);
                    chk("not_on_wall", (item_x >= 1 && item_x <= 46 && item_y >= 1 && item_y <= 62) ? 1 : 0, 1);
                end
            end
            done_d = done;
        end
    end

    task automatic issue(input int sz, output logic [5:0] x, output logic [5:0] y);
        exp_t e;
        int lat;
        size = 12'(sz);
        model(nxt(mlfsr), sz, x, y, lat);
        e.x = x; e.y = y; e.at = cyc + 1 + lat;
        q.push_back(e);
        req = 1'b1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 6000 && !done; i++) @(negedge clk);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic finish_req();
        req = 1'b0;
        @(negedge clk);
        chk("done_fall", int'(done), 0);
        @(negedge clk);
    endtask

    task automatic fill_row(input int n);
        bx = '0; by = '0;
        for (int k = 0; k < n && k < 100; k++) begin
            bx[k*6 +: 6] = 6'((k % 46) + 1);
            by[k*6 +: 6] = 6'd62;
        end
    endtask

    initial begin
        exp_t e;
        // Reset held with a pending request and an empty body.
        req = 1'b1; size = 12'd0;
        repeat (3) @(negedge clk);
        chk("rst_item_x", int'(item_x), 12);
        chk("rst_item_y", int'(item_y), 16);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_lfsr", int'(dut.lfsr), 12'hACE);
        // First DRAW sees 12'h59D -> (29,22), legal; size 0 commits after E2.
        e.x = 6'd29; e.y = 6'd22; e.at = cyc + 3;
        q.push_back(e);
        rst = 1'b1;
        wait_done();
        finish_req();

        // Wall rejection: start at a phase whose first candidate is on a wall.
        fill_row(2);
        for (int i = 0; i < 300 && !is_wall(nxt(mlfsr)); i++) @(negedge clk);
        chk("wall_phase_found", int'(is_wall(nxt(mlfsr))), 1);
        issue(2, ex, ey);
        wait_done();
        finish_req();

        // Body rejection: slot 1 holds the first legal candidate.
        for (int i = 0; i < 300 && is_wall(nxt(mlfsr)); i++) @(negedge clk);
        bx = '0; by = '0;
        bx[0 +: 6] = 6'd46; by[0 +: 6] = 6'd62;
        bx[6 +: 6] = nxt(mlfsr)[5:0];
        by[6 +: 6] = nxt(mlfsr)[11:6];
        bx[12 +: 6] = 6'd1; by[12 +: 6] = 6'd62;
        issue(3, ex, ey);
        wait_done();
        finish_req();

        // Size clamp: 4095 scans only 100 slots.
        fill_row(100);
        issue(4095, ex, ey);
        wait_done();
        finish_req();

        // Size 0 at an arbitrary phase.
        repeat (7) @(negedge clk);
        issue(0, ex, ey);
        wait_done();
        finish_req();

        // Handshake: hold request 10 cycles past done.
        fill_row(1);
        issue(1, ex, ey);
        wait_done();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_done", int'(done), 1);
            chk("hold_x", int'(item_x), int'(ex));
            chk("hold_y", int'(item_y), int'(ey));
        end
        finish_req();

        // One-cycle request pulse: DONE lasts exactly one cycle.
        fill_row(5);
        issue(5, ex, ey);
        @(negedge clk);
        req = 1'b0;
        wait_done();
        @(negedge clk);
        chk("pulse_done_len", int'(done), 0);
        @(negedge clk);

        // Async reset during a size-50 search.
        fill_row(50);
        issue(50, ex, ey);
        repeat (5) @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("abort_x", int'(item_x), 12);
        chk("abort_y", int'(item_y), 16);
        chk("abort_done", int'(done), 0);
        chk("abort_busy", int'(busy), 0);
        q.delete();
        req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_abort", int'(busy), 0);
        chk("sb_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
